spi_slave_rx_tx: RTL and testbench

- Clocked SPI slave endpoint that sits directly downstream of the team's SPI master on the SCLK/MOSI/MISO/chip-select wires. One instance attaches to each of the master's select lines (CS1, CS2 or CS3).
- Oversamples the serial lines on the local system clock and deserialises MOSI into a parallel word.
- Serialises a preloaded parallel word onto MISO, honouring all four CPOL/CPHA modes.
- Hands received words to local logic with a one-cycle valid pulse.

---
 rtl/spi_slave_rx_tx.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: oversampled SPI slave endpoint, all CPOL/CPHA modes; define SPI_SLAVE_MSB_FIRST_EN for MSB-first frames
module spi_slave_rx_tx #(
  parameter int sizeOfData = 8,
  parameter int syncStages = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [sizeOfData-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [sizeOfData-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  overrun,
  input  logic                  rx_ack,
  input  logic                  clr_flags
);
  localparam int CW = $clog2(sizeOfData + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;
  state_e state_q, state_d;
  logic [syncStages-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_hist_q, cs_hist_q;
  logic sclk_s, cs_s, mosi_s, sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
  logic cpol_q, cpol_d, cpha_q, cpha_d, miso_q, miso_d;
  logic [sizeOfData-1:0] tx_buf_q, tx_buf_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [sizeOfData-1:0] tx_src, tx_src_nx, tx_sh_nx, rx_next;
  logic tx_first, tx_bit;
  logic tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, pending_q, pending_d;
  logic underrun_q, underrun_d, overrun_q, overrun_d, start;
  logic [CW-1:0] cnt_q, cnt_d;
  assign sclk_s = sclk_sync_q[syncStages-1];
  assign cs_s = cs_sync_q[syncStages-1];
  assign mosi_s = mosi_sync_q[syncStages-1];
  assign sclk_edge = sclk_s ^ sclk_hist_q;
  assign lead_edge = sclk_edge & (sclk_hist_q == cpol_q);
  assign trail_edge = sclk_edge & (sclk_hist_q != cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge = cpha_q ? lead_edge : trail_edge;
  assign cs_fall = cs_hist_q & ~cs_s;
  assign tx_src = tx_full_q ? tx_buf_q : '0;
`ifdef SPI_SLAVE_MSB_FIRST_EN
  assign tx_first = tx_src[sizeOfData-1];
  assign tx_src_nx = tx_src << 1;
  assign tx_bit = tx_sh_q[sizeOfData-1];
  assign tx_sh_nx = tx_sh_q << 1;
  assign rx_next = (rx_sh_q << 1) | sizeOfData'(mosi_s);
`else
  assign tx_first = tx_src[0];
  assign tx_src_nx = tx_src >> 1;
  assign tx_bit = tx_sh_q[0];
  assign tx_sh_nx = tx_sh_q >> 1;
  assign rx_next = (rx_sh_q >> 1) | (sizeOfData'(mosi_s) << (sizeOfData - 1));
`endif
  assign miso = miso_q;
  assign tx_ready = ~tx_full_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy = state_q != IDLE;
  assign underrun = underrun_q;
  assign overrun = overrun_q;
  // input synchronisers plus one history flop; cs_n idles high so its chain resets to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[syncStages-2:0], sclk};
      cs_sync_q <= {cs_sync_q[syncStages-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[syncStages-2:0], mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q <= cs_s;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      miso_q <= 1'b0;
      tx_buf_q <= '0;
      tx_full_q <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      pending_q <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      miso_q <= miso_d;
      tx_buf_q <= tx_buf_d;
      tx_full_q <= tx_full_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      pending_q <= pending_d;
      underrun_q <= underrun_d;
      overrun_q <= overrun_d;
      cnt_q <= cnt_d;
    end
  end
  // frame sequencing, shifting and status flags; rx_valid_q marks the single DONE cycle where ack/overrun resolve
  always_comb begin
    state_d = state_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    miso_d = miso_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;
    cnt_d = cnt_q;
    rx_valid_d = 1'b0;
    start = 1'b0;
    tx_buf_d = tx_load ? tx_data : tx_buf_q;
    tx_full_d = tx_load | tx_full_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          start = 1'b1;
          state_d = ACTIVE;
          cpol_d = cpol;
          cpha_d = cpha;
          tx_sh_d = cpha ? tx_src : tx_src_nx;
          miso_d = cpha ? 1'b0 : tx_first;
          tx_full_d = tx_load;
          rx_sh_d = '0;
          cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d = IDLE;
          miso_d = 1'b0;
        end else begin
          if (shift_edge) begin
            miso_d = tx_bit;
            tx_sh_d = tx_sh_nx;
          end
          if (sample_edge) begin
            rx_sh_d = rx_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(sizeOfData - 1)) begin
              state_d = DONE;
              miso_d = 1'b0;
              rx_data_d = rx_next;
              rx_valid_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        state_d = cs_s ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
    pending_d = rx_valid_q | (pending_q & ~rx_ack);
    overrun_d = (rx_valid_q & pending_q & ~rx_ack) | (overrun_q & ~clr_flags);
    underrun_d = (start & ~tx_full_q) | (underrun_q & ~clr_flags);
  end
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// tb_spi_slave_rx_tx: directed table plus randomized frames against a frame-level reference model
module tb_spi_slave_rx_tx;
  logic clk = 0, rst_n = 0, sclk = 0, cs_n = 1, mosi = 0, cpol = 0, cpha = 0;
  logic tx_load = 0, ack_man = 0, auto_en = 0, clr_flags = 0;
  logic [7:0] tx_data = 0;
  logic [7:0] rx_data;
  logic miso, tx_ready, rx_valid, busy, underrun, overrun, rx_ack;
  int checks = 0, errors = 0, nvalid = 0;
  typedef struct {
    logic pol, pha, load;
    logic [7:0] txw, mo;
    int nbits;
    logic ack, clr, aut;
    logic [7:0] exp_mi, exp_rx;
    int exp_nv;
    logic exp_under, exp_over;
  } vec_t;
  vec_t tbl[9];
  vec_t v;
  logic [7:0] m_buf, m_rx;
  logic m_full, m_pend, m_under, m_over;
  logic [7:0] mi_r;
  int v0;

  spi_slave_rx_tx #(.sizeOfData(8), .syncStages(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .underrun(underrun),
    .overrun(overrun), .rx_ack(rx_ack), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;
  assign rx_ack = ack_man | (auto_en & rx_valid);
  always @(negedge clk) if (rx_valid) nvalid <= nvalid + 1;

  function automatic logic [7:0] map8(input logic [7:0] x);
    logic [7:0] r;
`ifdef SPI_SLAVE_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
`else
    r = x;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] w);
    @(negedge clk);
    tx_data = w;
    tx_load = 1;
    @(negedge clk);
    tx_load = 0;
    check("tx_ready_after_load", tx_ready, 0);
  endtask

  task automatic pulse_ack();
    @(negedge clk); ack_man = 1;
    @(negedge clk); ack_man = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_flags = 1;
    @(negedge clk); clr_flags = 0;
  endtask

  // SPI master: frame bit i of mo goes out as the i-th bit; mi collects the returned frame bits
  task automatic frame(input logic pol, input logic pha, input logic [7:0] mo, input int nbits,
                       input int rst_bit, output logic [7:0] mi);
    mi = 0;
    cpol = pol;
    cpha = pha;
    sclk = pol;
    mosi = 0;
    half();
    cs_n = 0;
    mosi = pha ? 1'b0 : mo[0];
    half();
    check("busy_mid_frame", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_n = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        cs_n = 1;
        sclk = pol;
        repeat (4) @(negedge clk);
        rst_n = 1;
        half();
        return;
      end
      if (pha) begin
        sclk = ~pol; mosi = mo[i]; half();
        mi[i] = miso; sclk = pol; half();
      end else begin
        mi[i] = miso; sclk = ~pol; half();
        sclk = pol;
        if (i < 7) mosi = mo[i+1];
        half();
      end
    end
    cs_n = 1;
    half();
    half();
  endtask

  task automatic run(input vec_t t, input string tag);
    logic [7:0] mi, mask;
    int base;
    if (t.load) load(t.txw);
    base = nvalid;
    auto_en = t.aut;
    frame(t.pol, t.pha, t.mo, t.nbits, -1, mi);
    auto_en = 0;
    mask = 0;
    for (int j = 0; j < t.nbits; j++) mask[j] = 1'b1;
    check({tag, "_miso"}, mi & mask, map8(t.exp_mi) & mask);
    check({tag, "_rx_data"}, rx_data, map8(t.exp_rx));
    check({tag, "_rx_valid_count"}, nvalid - base, t.exp_nv);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_underrun"}, underrun, t.exp_under);
    check({tag, "_overrun"}, overrun, t.exp_over);
    if (t.ack) pulse_ack();
    if (t.clr) pulse_clr();
  endtask

  // frame-level model: buffer handoff, pending word and sticky flags
  task automatic predict(inout vec_t t);
    if (t.load) begin m_buf = t.txw; m_full = 1; end
    t.exp_mi = m_full ? map8(m_buf) : 8'h00;
    if (!m_full) m_under = 1;
    m_full = 0;
    if (t.nbits == 8) begin
      if (m_pend && !t.aut) m_over = 1;
      m_pend = 1;
      m_rx = t.mo;
    end
    t.exp_rx = m_rx;
    t.exp_nv = (t.nbits == 8) ? 1 : 0;
    t.exp_under = m_under;
    t.exp_over = m_over;
    if (t.ack) m_pend = 0;
    if (t.clr) begin m_under = 0; m_over = 0; end
  endtask

  initial begin
    // pol pha load txw mo nbits ack clr aut | exp_mi exp_rx nv under over
    tbl[0] = '{0, 0, 1, 8'hA5, 8'h3C, 8, 1, 0, 0, 8'hA5, 8'h3C, 1, 0, 0};
    tbl[1] = '{1, 1, 1, 8'h81, 8'hFF, 8, 1, 0, 0, 8'h81, 8'hFF, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 8'h00, 8'h12, 8, 1, 1, 0, 8'h00, 8'h12, 1, 1, 0};
    tbl[3] = '{0, 1, 1, 8'h33, 8'h0F, 4, 0, 0, 0, 8'h33, 8'h12, 0, 0, 0};
    tbl[4] = '{1, 0, 0, 8'h00, 8'h55, 8, 1, 1, 0, 8'h00, 8'h55, 1, 1, 0};
    tbl[5] = '{0, 0, 1, 8'h5A, 8'h01, 8, 0, 0, 0, 8'h5A, 8'h01, 1, 0, 0};
    tbl[6] = '{1, 1, 1, 8'h7E, 8'h02, 8, 1, 1, 0, 8'h7E, 8'h02, 1, 0, 1};
    tbl[7] = '{0, 1, 1, 8'h11, 8'h03, 8, 0, 0, 0, 8'h11, 8'h03, 1, 0, 0};
    tbl[8] = '{1, 0, 1, 8'h22, 8'h04, 8, 1, 0, 1, 8'h22, 8'h04, 1, 0, 0};
    repeat (3) @(negedge clk);
    check("reset_miso", miso, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_underrun", underrun, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1;
    half();
    for (int i = 0; i < 9; i++) begin
      v = tbl[i];
      v.exp_mi = map8(v.exp_mi);
      run(v, "dir");
    end
    load(8'h99);
    v0 = nvalid;
    frame(0, 0, 8'hF0, 8, 3, mi_r);
    check("rst_no_rx_valid", nvalid - v0, 0);
    check("rst_busy_after", busy, 0);
    check("rst_underrun_after", underrun, 0);
    m_buf = 0; m_rx = 0; m_full = 0; m_pend = 0; m_under = 0; m_over = 0;
    v = '{0, 0, 0, 8'h00, 8'h66, 8, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0};
    predict(v);
    run(v, "post_rst");
    for (int k = 0; k < 30; k++) begin
      v.pol = 1'($urandom_range(0, 1));
      v.pha = 1'($urandom_range(0, 1));
      v.load = ($urandom_range(0, 3) != 0);
      v.txw = 8'($urandom);
      v.mo = 8'($urandom);
      v.nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      v.ack = 1'($urandom_range(0, 1));
      v.clr = ($urandom_range(0, 3) == 0);
      v.aut = 1'($urandom_range(0, 1));
      predict(v);
      run(v, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
